dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Two-master, one-slave arbiter for the data bus between the masters and the bridge (DRAM plus memory-mapped peripherals).
- Master 0 is the CPU data port. Master 1 is a secondary master (debug/loader DMA).
- Round-robin grant; one outstanding transaction at a time.
- Latches the winner's request, drives the slave until it acknowledges, then returns read data and a one-cycle ack to the winner.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, cycles waited for s_ack before abort (used only with the optional feature)

Ports:
- cpu_clk  in  1  clock; all logic is on the rising edge
- cpu_rst  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_we  in  1  master 0 write enable (1 = write)
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  one-cycle completion pulse to master 0
- m0_rdata  out  DATA_W  read data to master 0; valid while m0_ack is high
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1
- s_req  out  1  slave request; held high until s_ack
- s_we  out  1  slave write enable
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data; sampled when s_ack is high
- s_ack  in  1  slave completion; single cycle, at least 1 cycle after s_req rises
- busy  out  1  high in the BUSY and DONE states
- owner  out  1  index of the current or last granted master

Behaviour:
- Reset (cpu_rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0. This includes m*_rdata, s_addr, s_wdata and owner.
  - The last-served pointer goes to 1, so master 0 wins the first tie.
- States and transitions:
  - IDLE: when any m*_req is high, select the winner and latch its we/addr/wdata into the s_* registers. Set owner and go to BUSY.
  - Arbitration:
    - Only one request high: that master wins.
    - Both high: the master that is not the last-served one wins.
  - BUSY: s_req = 1 and s_we/s_addr/s_wdata are held stable. Master inputs are ignored. On s_ack:
    - capture s_rdata into the owner's m*_rdata;
    - set the last-served pointer to owner;
    - go to DONE.
  - DONE: the owner's m*_ack = 1 for exactly this cycle and s_req = 0. Next state is always IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 → s_req high from cycle 1.
  - s_ack at cycle k → m*_ack at cycle k+1.
  - Minimum is 3 cycles per transaction.
- m*_rdata holds its value until that master's next completion. On writes it is updated with s_rdata (don't-care content).
- A master dropping req in BUSY does not abort the transaction; the ack is still pulsed.
- The non-owner's req waiting during BUSY/DONE is served in the next IDLE.
- s_ack outside BUSY is ignored.
- Reset asserted mid-transaction: s_req drops immediately (asynchronously) and no ack is issued. Masters must reissue.
- m0_ack and m1_ack are never high in the same cycle.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN
- With the macro:
  - Adds output port bus_err (1 bit, resets to 0).
  - A counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When it reaches TIMEOUT_CYC:
    - drop s_req;
    - go to DONE with the owner's m*_rdata = all-ones;
    - pulse the owner's ack together with bus_err = 1 for one cycle.
  - An s_ack arriving in the same cycle the counter reaches TIMEOUT_CYC takes priority: normal completion, bus_err = 0.
- Without the macro: no bus_err port and no counter; BUSY waits indefinitely.

Decomposition:
- Shared package/header: state encodings (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2), master index constants, and the error read value 32'hFFFF_FFFF.
- One natural sub-module, rr_pick2: combinational round-robin choice from two requests and the last-served pointer. It outputs the grant index and a valid flag.
- Everything else (FSM, latches, timeout counter) lives in dbus_arbiter.

Test Plan:
- Reset check: cpu_rst low mid-BUSY → s_req falls the same cycle, all outputs 0, state IDLE after release.
- Single read: m0_req, addr 0x8010_0000, slave acks 2 cycles after s_req with 0x1234_5678 → m0_ack pulses one cycle later with m0_rdata = 0x1234_5678, m1_ack stays 0.
- Contention:
  - both masters request from reset → m0 granted first, then m1, alternating over 4 back-to-back requests each;
  - owner sequence 0,1,0,1,0,1,0,1;
  - no ack overlap.
- Write pass-through: m1 write, addr 0x8020_0004, data 0xDEAD_BEEF → s_we = 1 with that addr/data, held stable until s_ack.
- Request withdrawal: m0 drops req during BUSY → transaction completes and m0_ack still pulses; m1 pending → m1 granted in the following IDLE.
- With DBUS_TIMEOUT_EN, TIMEOUT_CYC = 4:
  - no s_ack → after 4 BUSY cycles, m0_ack + bus_err pulse with m0_rdata = 0xFFFF_FFFF;
  - s_ack on the 4th cycle → normal completion, bus_err = 0.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter: FSM encodings, master
// indices and the value returned to a master on a bus timeout.
package dbus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dbus_state_e;

  localparam logic MST_CPU = 1'b0;  // master 0: CPU data port
  localparam logic MST_DMA = 1'b1;  // master 1: debug/loader DMA

  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/dbus_arbiter_rr_pick2.sv
// Combinational two-way round-robin choice.
//   req0, req1 : requests from master 0 / master 1
//   last       : index of the master served most recently
//   grant_c    : winning master index (meaningful only when valid_c)
//   valid_c    : at least one request is pending
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_c,
  output logic valid_c
);

  // On a tie the master that was not served last wins; otherwise the sole requester.
  always_comb begin
    valid_c = req0 | req1;
    grant_c = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master, one-slave data-bus arbiter with round-robin grant and a single
// outstanding transaction. The winner's request is latched onto the slave
// port, held until s_ack, and the read data plus a one-cycle ack are returned.
//   cpu_clk, cpu_rst        : clock, async active-low reset
//   m0_*/m1_*               : master request/we/addr/wdata in, ack/rdata out
//   s_*                     : slave request/we/addr/wdata out, rdata/ack in
//   busy                    : high in BUSY and DONE
//   owner                   : index of the current or last granted master
//   bus_err                 : timeout flag pulsed with the ack (DBUS_TIMEOUT_EN only)
// Build option: define DBUS_TIMEOUT_EN to abort slave accesses that exceed
// TIMEOUT_CYC busy cycles.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  output logic              busy,
`ifdef DBUS_TIMEOUT_EN
  output logic              bus_err,
`endif
  output logic              owner
);

  // A zero timeout would make the abort compare underflow.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("dbus_arbiter: TIMEOUT_CYC must be at least 1");
  end

  dbus_state_e       state_q, state_d;
  logic              last_q, last_d;
  logic              s_req_d, s_we_d, busy_d, owner_d;
  logic [ADDR_W-1:0] s_addr_d;
  logic [DATA_W-1:0] s_wdata_d, m0_rdata_d, m1_rdata_d;
  logic              m0_ack_d, m1_ack_d;
  logic              pick_grant_c, pick_valid_c;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             bus_err_d;
`endif

  rr_pick2 u_pick (
    .req0    (m0_req),
    .req1    (m1_req),
    .last    (last_q),
    .grant_c (pick_grant_c),
    .valid_c (pick_valid_c)
  );

  // State and output registers; reset drops s_req immediately.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q  <= ST_IDLE;
      last_q   <= MST_DMA;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      busy     <= 1'b0;
      owner    <= MST_CPU;
`ifdef DBUS_TIMEOUT_EN
      tmo_cnt_q <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      s_req    <= s_req_d;
      s_we     <= s_we_d;
      s_addr   <= s_addr_d;
      s_wdata  <= s_wdata_d;
      m0_ack   <= m0_ack_d;
      m1_ack   <= m1_ack_d;
      m0_rdata <= m0_rdata_d;
      m1_rdata <= m1_rdata_d;
      busy     <= busy_d;
      owner    <= owner_d;
`ifdef DBUS_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      bus_err   <= bus_err_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    s_req_d    = 1'b0;
    s_we_d     = s_we;
    s_addr_d   = s_addr;
    s_wdata_d  = s_wdata;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
    owner_d    = owner;
`ifdef DBUS_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    bus_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          state_d   = ST_BUSY;
          owner_d   = pick_grant_c;
          s_req_d   = 1'b1;
          s_we_d    = (pick_grant_c == MST_DMA) ? m1_we    : m0_we;
          s_addr_d  = (pick_grant_c == MST_DMA) ? m1_addr  : m0_addr;
          s_wdata_d = (pick_grant_c == MST_DMA) ? m1_wdata : m0_wdata;
`ifdef DBUS_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      ST_BUSY: begin
        s_req_d = 1'b1;
        if (s_ack) begin
          state_d = ST_DONE;
          s_req_d = 1'b0;
          last_d  = owner;
          if (owner == MST_DMA) begin
            m1_rdata_d = s_rdata;
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = s_rdata;
            m0_ack_d   = 1'b1;
          end
        end
`ifdef DBUS_TIMEOUT_EN
        // The cycle in which the count would reach TIMEOUT_CYC aborts the access.
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_DONE;
          s_req_d   = 1'b0;
          last_d    = owner;
          bus_err_d = 1'b1;
          if (owner == MST_DMA) begin
            m1_rdata_d = DATA_W'(ERR_RDATA);
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = DATA_W'(ERR_RDATA);
            m0_ack_d   = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point.
module tb_dbus_arbiter;

  logic        cpu_clk, cpu_rst;
  logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_we, s_ack, busy, owner;
  logic [31:0] s_addr, s_wdata, s_rdata;
`ifdef DBUS_TIMEOUT_EN
  logic        bus_err;
`endif

  int checks   = 0;
  int failures = 0;

  dbus_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef DBUS_TIMEOUT_EN
    , .TIMEOUT_CYC (4)
`endif
  ) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ack    (s_ack),
    .busy     (busy),
`ifdef DBUS_TIMEOUT_EN
    .bus_err  (bus_err),
`endif
    .owner    (owner)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Advance until the slave request rises, bounded to 20 cycles.
  task automatic wait_s_req(input string tag);
    for (int n = 0; n < 20 && s_req !== 1'b1; n++) tick();
    check_eq(tag, 32'(s_req), 32'd1);
  endtask

  task automatic do_reset();
    cpu_rst = 1'b0;
    tick();
    tick();
    cpu_rst = 1'b1;
    tick();
  endtask

  int left0, left1;
  logic exp_own;

  initial begin
    cpu_clk = 1'b0;
    cpu_rst = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;

    // Reset state
    do_reset();
    check_eq("rst_s_req", 32'(s_req), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd0);
    check_eq("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);

    // Single read from master 0, slave acks 2 cycles after s_req
    m0_req = 1'b1; m0_addr = 32'h8010_0000;
    tick();
    check_eq("rd_s_req", 32'(s_req), 32'd1);
    check_eq("rd_s_addr", s_addr, 32'h8010_0000);
    check_eq("rd_s_we", 32'(s_we), 32'd0);
    check_eq("rd_busy", 32'(busy), 32'd1);
    tick();
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    s_ack = 1'b0; m0_req = 1'b0;
    check_eq("rd_m0_ack", 32'(m0_ack), 32'd1);
    check_eq("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    check_eq("rd_m1_ack", 32'(m1_ack), 32'd0);
    check_eq("rd_done_s_req", 32'(s_req), 32'd0);
    tick();
    check_eq("rd_ack_pulse", 32'(m0_ack), 32'd0);
    check_eq("rd_idle_busy", 32'(busy), 32'd0);

    // Contention from reset: four requests each, expect 0,1,0,1,...
    do_reset();
    m0_addr = 32'h1000_0000; m1_addr = 32'h2000_0000;
    m0_req = 1'b1; m1_req = 1'b1;
    left0 = 4; left1 = 4;
    for (int i = 0; i < 8; i++) begin
      exp_own = i[0];
      wait_s_req("cont_s_req");
      check_eq("cont_owner", 32'(owner), 32'(exp_own));
      check_eq("cont_s_addr", s_addr, exp_own ? 32'h2000_0000 : 32'h1000_0000);
      s_ack = 1'b1; s_rdata = 32'hC0DE_0000 + 32'(i);
      tick();
      s_ack = 1'b0;
      check_eq("cont_ack_overlap", 32'(m0_ack & m1_ack), 32'd0);
      if (exp_own) begin
        check_eq("cont_m1_ack", 32'(m1_ack), 32'd1);
        check_eq("cont_m1_rdata", m1_rdata, 32'hC0DE_0000 + 32'(i));
        left1--;
        if (left1 == 0) m1_req = 1'b0;
      end else begin
        check_eq("cont_m0_ack", 32'(m0_ack), 32'd1);
        check_eq("cont_m0_rdata", m0_rdata, 32'hC0DE_0000 + 32'(i));
        left0--;
        if (left0 == 0) m0_req = 1'b0;
      end
    end
    tick();
    tick();
    check_eq("cont_idle_s_req", 32'(s_req), 32'd0);

    // Write pass-through from master 1; master inputs change but slave side holds
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8020_0004; m1_wdata = 32'hDEAD_BEEF;
    wait_s_req("wr_s_req");
    check_eq("wr_owner", 32'(owner), 32'd1);
    check_eq("wr_s_we", 32'(s_we), 32'd1);
    check_eq("wr_s_addr", s_addr, 32'h8020_0004);
    check_eq("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    tick();
    tick();
    check_eq("wr_hold_s_req", 32'(s_req), 32'd1);
    check_eq("wr_hold_s_we", 32'(s_we), 32'd1);
    check_eq("wr_hold_s_addr", s_addr, 32'h8020_0004);
    check_eq("wr_hold_s_wdata", s_wdata, 32'hDEAD_BEEF);
    s_ack = 1'b1; s_rdata = 32'hA5A5_0000;
    tick();
    s_ack = 1'b0; m1_req = 1'b0;
    check_eq("wr_m1_ack", 32'(m1_ack), 32'd1);
    check_eq("wr_m0_ack", 32'(m0_ack), 32'd0);
    tick();

    // Master 0 withdraws during BUSY while master 1 waits
    m0_req = 1'b1; m0_addr = 32'h8010_0100;
    wait_s_req("wd_s_req");
    check_eq("wd_owner0", 32'(owner), 32'd0);
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h8020_0200;
    tick();
    check_eq("wd_still_busy", 32'(s_req), 32'd1);
    s_ack = 1'b1; s_rdata = 32'h0BAD_F00D;
    tick();
    s_ack = 1'b0;
    check_eq("wd_m0_ack", 32'(m0_ack), 32'd1);
    check_eq("wd_m0_rdata", m0_rdata, 32'h0BAD_F00D);
    check_eq("wd_m1_ack_low", 32'(m1_ack), 32'd0);
    tick();
    tick();
    check_eq("wd_m1_s_req", 32'(s_req), 32'd1);
    check_eq("wd_owner1", 32'(owner), 32'd1);
    check_eq("wd_m1_s_addr", s_addr, 32'h8020_0200);
    s_ack = 1'b1; s_rdata = 32'h7777_1111;
    tick();
    s_ack = 1'b0; m1_req = 1'b0;
    check_eq("wd_m1_ack", 32'(m1_ack), 32'd1);
    check_eq("wd_m1_rdata", m1_rdata, 32'h7777_1111);
    tick();

`ifdef DBUS_TIMEOUT_EN
    // No slave ack: abort after four BUSY cycles
    m0_req = 1'b1; m0_addr = 32'h8030_0000;
    wait_s_req("to_s_req");
    tick(); tick(); tick();
    check_eq("to_busy4_s_req", 32'(s_req), 32'd1);
    check_eq("to_busy4_ack", 32'(m0_ack), 32'd0);
    tick();
    m0_req = 1'b0;
    check_eq("to_m0_ack", 32'(m0_ack), 32'd1);
    check_eq("to_bus_err", 32'(bus_err), 32'd1);
    check_eq("to_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
    check_eq("to_s_req_low", 32'(s_req), 32'd0);
    tick();
    check_eq("to_err_pulse", 32'(bus_err), 32'd0);

    // Slave ack on the fourth BUSY cycle wins over the timeout
    m0_req = 1'b1;
    wait_s_req("tk_s_req");
    tick(); tick(); tick();
    s_ack = 1'b1; s_rdata = 32'h4444_0004;
    tick();
    s_ack = 1'b0; m0_req = 1'b0;
    check_eq("tk_m0_ack", 32'(m0_ack), 32'd1);
    check_eq("tk_bus_err", 32'(bus_err), 32'd0);
    check_eq("tk_m0_rdata", m0_rdata, 32'h4444_0004);
    tick();
`endif

    // Reset asserted mid-BUSY
    m0_req = 1'b1; m0_addr = 32'h8010_0300; m0_wdata = 32'h5555_AAAA;
    wait_s_req("mr_s_req");
    #2;
    cpu_rst = 1'b0;
    #1;
    check_eq("mr_s_req", 32'(s_req), 32'd0);
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_owner", 32'(owner), 32'd0);
    check_eq("mr_s_addr", s_addr, 32'h0);
    check_eq("mr_s_wdata", s_wdata, 32'h0);
    check_eq("mr_m0_rdata", m0_rdata, 32'h0);
    check_eq("mr_m1_rdata", m1_rdata, 32'h0);
    check_eq("mr_acks", 32'({m0_ack, m1_ack}), 32'd0);
    m0_req = 1'b0;
    tick();
    cpu_rst = 1'b1;
    tick();
    check_eq("mr_idle_busy", 32'(busy), 32'd0);
    check_eq("mr_idle_s_req", 32'(s_req), 32'd0);
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    check_eq("mr_first_owner", 32'(owner), 32'd0);
    check_eq("mr_first_s_req", 32'(s_req), 32'd1);
    m0_req = 1'b0; m1_req = 1'b0;
    s_ack = 1'b1; s_rdata = 32'h0;
    tick();
    s_ack = 1'b0;
    check_eq("mr_first_ack", 32'(m0_ack), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
